// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_mmio
//  Purpose  : MEM-stage data memory for the 16-bit CPU. Decodes each access
//             to either a word RAM (asynchronous read, aliased) or a 256-byte
//             I/O page holding a timer, an output port and a TX FIFO.
//  Options  : DMEM_TIMER_EN - when defined, builds TIMER/TCTRL/TCMP and
//             timer_irq; otherwise those offsets read 0 and timer_irq is 0.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_mmio #(
  parameter int          RAM_AW  = 7,
  parameter int          FIFO_AW = 2,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dmemaddr,
  input  logic [15:0] dmemwdata,
  input  logic        dmemwrite,
  input  logic        dmemread,
  output logic [15:0] dmemrdata,
  output logic [15:0] out_port,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int DEPTH = 1 << FIFO_AW;

  // I/O register word offsets (byte offset >> 1)
  localparam logic [6:0] W_TIMER  = 7'h00;
  localparam logic [6:0] W_TCTRL  = 7'h01;
  localparam logic [6:0] W_TCMP   = 7'h02;
  localparam logic [6:0] W_OUT    = 7'h03;
  localparam logic [6:0] W_TXDATA = 7'h04;
  localparam logic [6:0] W_TXSTAT = 7'h05;

  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic              is_io;
  logic [6:0]        io_word;
  logic              io_wr;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_lsb;

  assign is_io           = (dmemaddr[15:8] == IO_BASE[15:8]);
  assign io_word         = dmemaddr[7:1];
  assign io_wr           = dmemwrite && is_io;
  assign ram_idx         = dmemaddr[RAM_AW:1];
  assign unused_addr_lsb = dmemaddr[0];   // byte lane select is not used

  // --------------------------------------------------------------------------
  // Word RAM: contents survive reset, upper address bits alias
  // --------------------------------------------------------------------------
  logic [15:0] ram_q [2**RAM_AW];

  // RAM write port; reset blocks a same-cycle store
  always_ff @(posedge clock) begin
    if (!reset && dmemwrite && !is_io) begin
      ram_q[ram_idx] <= dmemwdata;
    end
  end

  // --------------------------------------------------------------------------
  // Output port, TX FIFO and overflow flag
  // --------------------------------------------------------------------------
  logic [15:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        out_q, out_d;
  logic               fifo_full, fifo_empty;
  logic               push_req, push, pop, ovf_clr;

  // count can never exceed DEPTH, so its MSB alone marks the full state
  assign fifo_full  = count_q[FIFO_AW];
  assign fifo_empty = (count_q == '0);
  assign push_req   = io_wr && (io_word == W_TXDATA);
  assign push       = push_req && !fifo_full;   // full is judged pre-edge
  assign pop        = !fifo_empty && tx_ready;
  assign ovf_clr    = io_wr && (io_word == W_TXSTAT) && dmemwdata[2];

  // Next-state for pointers, occupancy, overflow and the output register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // a dropped push sets overflow even when a clear lands on the same edge
    ovf_d = (push_req && fifo_full) || (ovf_q && !ovf_clr);
    if (io_wr && (io_word == W_OUT)) out_d = dmemwdata;
  end

  // State registers for FIFO control and the output port
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      out_q    <= out_d;
    end
  end

  // FIFO storage; pointers are reset so stale contents are never visible
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr_q] <= dmemwdata;
    end
  end

  assign out_port = out_q;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Timer with compare flag and registered interrupt
  // --------------------------------------------------------------------------
  logic [15:0] timer_rd, tctrl_rd, tcmp_rd;

`ifdef DMEM_TIMER_EN
  logic [15:0] timer_q, timer_d;
  logic [15:0] tcmp_q, tcmp_d;
  logic        en_q, en_d;
  logic        irqen_q, irqen_d;
  logic        flag_q, flag_d;
  logic        irq_q, irq_d;
  logic        flag_set, flag_clr;

  assign flag_set = en_q && (timer_q == tcmp_q);
  assign flag_clr = io_wr && (io_word == W_TCTRL) && dmemwdata[2];

  // Timer next-state: a software load beats the free-running increment
  always_comb begin
    timer_d = timer_q;
    tcmp_d  = tcmp_q;
    en_d    = en_q;
    irqen_d = irqen_q;
    if (io_wr && (io_word == W_TIMER)) begin
      timer_d = dmemwdata;
    end else if (en_q) begin
      timer_d = timer_q + 16'd1;
    end
    if (io_wr && (io_word == W_TCMP)) tcmp_d = dmemwdata;
    if (io_wr && (io_word == W_TCTRL)) begin
      en_d    = dmemwdata[0];
      irqen_d = dmemwdata[1];
    end
    flag_d = flag_set || (flag_q && !flag_clr);
    irq_d  = flag_q && irqen_q;   // lags flag/irqen by one cycle
  end

  // Timer state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
      tcmp_q  <= '0;
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
      flag_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tcmp_q  <= tcmp_d;
      en_q    <= en_d;
      irqen_q <= irqen_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  assign timer_rd  = timer_q;
  assign tctrl_rd  = {13'b0, flag_q, irqen_q, en_q};
  assign tcmp_rd   = tcmp_q;
  assign timer_irq = irq_q;
`else
  assign timer_rd  = 16'h0000;
  assign tctrl_rd  = 16'h0000;
  assign tcmp_rd   = 16'h0000;
  assign timer_irq = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Read mux: combinational, shows pre-edge state even during a write
  // --------------------------------------------------------------------------
  logic [15:0] txstat_rd;
  assign txstat_rd = {9'b0, 3'(count_q), 1'b0, ovf_q, fifo_full, fifo_empty};

  // Select read data from the decoded target; idle bus reads as zero
  always_comb begin
    dmemrdata = 16'h0000;
    if (dmemread) begin
      if (is_io) begin
        case (io_word)
          W_TIMER:  dmemrdata = timer_rd;
          W_TCTRL:  dmemrdata = tctrl_rd;
          W_TCMP:   dmemrdata = tcmp_rd;
          W_OUT:    dmemrdata = out_q;
          W_TXSTAT: dmemrdata = txstat_rd;
          default:  dmemrdata = 16'h0000;
        endcase
      end else begin
        dmemrdata = ram_q[ram_idx];
      end
    end
  end

endmodule
`default_nettype wire
